gemm_array_ctrl: RTL

Parametrised output-stationary GEMM engine: a ROWS×COLS grid of signed INT8-class MAC processing elements, with built-in input skewing, a K-length sequencing FSM, a flush phase and a row-by-row result drain over a valid/ready stream. It computes C = A·B for one output tile of ROWS×COLS.
- A is ROWS×K; B is K×COLS; K is chosen per job at run time.
- It sits between the operand DMA/scratchpad (one A column and one B row per beat) and the result write-back path, and takes over from the fixed-size, externally skewed array.

---
 rtl/gemm_pkg.sv | 28 ++
 rtl/gemm_mac_pe.sv | 39 +++
 rtl/gemm_array_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/gemm_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gemm_pkg : shared types and constants for the GEMM array engine     |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
package gemm_pkg;

  localparam int DEF_ROWS     = 16;
  localparam int DEF_COLS     = 16;
  localparam int FLUSH_CYCLES = DEF_ROWS + DEF_COLS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef logic signed [7:0]  operand_t;
  typedef logic signed [31:0] accum_t;

  // The longest skewed operand path through a rows x cols grid.
  function automatic int flush_cycles(input int rows, input int cols);
    return rows + cols;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gemm_mac_pe.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gemm_mac_pe : output-stationary signed MAC with registered passthru |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module gemm_mac_pe #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACCUM_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic signed [DATA_WIDTH-1:0]  a_in,
  input  logic signed [DATA_WIDTH-1:0]  b_in,
  output logic signed [DATA_WIDTH-1:0]  a_out,
  output logic signed [DATA_WIDTH-1:0]  b_out,
  output logic signed [ACCUM_WIDTH-1:0] acc
);

  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [ACCUM_WIDTH-1:0]  w_prod_ext;

  assign w_prod     = a_in * b_in;
  assign w_prod_ext = ACCUM_WIDTH'(w_prod);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= clear ? '0 : acc + w_prod_ext;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gemm_array_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gemm_array_ctrl : skewed output-stationary GEMM tile with row drain |
// | rev 1.0                                                             |
// +--------------------------------------------------------------------+
module gemm_array_ctrl
  import gemm_pkg::*;
#(
  parameter int ROWS        = 16,
  parameter int COLS        = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int ACCUM_WIDTH = 32,
  parameter int K_WIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [K_WIDTH-1:0]            k_len,
  output logic                          busy,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]    a_data,
  input  logic [COLS*DATA_WIDTH-1:0]    b_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(ROWS)-1:0]       out_row,
  output logic [COLS*ACCUM_WIDTH-1:0]   out_data,
  output logic                          out_last,
  output logic                          done
);

  localparam int ROW_W     = $clog2(ROWS);
  localparam int FLUSH_LEN = flush_cycles(ROWS, COLS);
  localparam int FLUSH_W   = $clog2(FLUSH_LEN + 1);

  state_t                r_state;
  state_t                w_next_state;
  logic [K_WIDTH-1:0]    r_k_len;
  logic [K_WIDTH-1:0]    r_beat_cnt;
  logic [FLUSH_W-1:0]    r_flush_cnt;
  logic [ROW_W-1:0]      r_row;
  logic                  r_clear;
  logic                  r_out_valid;
  logic                  r_done;

  logic                  w_beat;
  logic                  w_last_beat;
  logic                  w_out_fire;
  logic                  w_last_row;
  logic                  w_start_ok;
  logic [ROWS*DATA_WIDTH-1:0] w_a_feed;
  logic [COLS*DATA_WIDTH-1:0] w_b_feed;

  logic signed [DATA_WIDTH-1:0]  w_a   [ROWS][COLS+1];
  logic signed [DATA_WIDTH-1:0]  w_b   [ROWS+1][COLS];
  logic signed [ACCUM_WIDTH-1:0] w_acc [ROWS][COLS];

  assign w_beat      = in_valid && in_ready;
  assign w_last_beat = (r_beat_cnt + K_WIDTH'(1)) == r_k_len;
  assign w_out_fire  = r_out_valid && out_ready;
  assign w_last_row  = (r_row == ROW_W'(ROWS - 1));
  assign w_start_ok  = (r_state == IDLE) && start;

  // Idle cycles and bubbles feed zeros so the skew keeps shifting cleanly.
  assign w_a_feed = w_beat ? a_data : '0;
  assign w_b_feed = w_beat ? b_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = (k_len == '0) ? DRAIN : LOAD;
      LOAD:    if (w_beat && w_last_beat) w_next_state = FLUSH;
      FLUSH:   if (r_flush_cnt == FLUSH_W'(FLUSH_LEN - 1)) w_next_state = DRAIN;
      DRAIN:   if (w_out_fire && w_last_row) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != IDLE);
    in_ready = (r_state == LOAD);
    out_last = r_out_valid && w_last_row;
  end

  // out_valid lags DRAIN entry by a cycle so every accumulator has settled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k_len     <= '0;
      r_beat_cnt  <= '0;
      r_flush_cnt <= '0;
      r_row       <= '0;
      r_clear     <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_clear     <= w_start_ok;
      r_out_valid <= (r_state == DRAIN) && (w_next_state == DRAIN);
      r_done      <= (r_state == DRAIN) && (w_next_state == IDLE);
      if (w_start_ok) begin
        r_k_len    <= k_len;
        r_beat_cnt <= '0;
      end else if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      r_flush_cnt <= (r_state == FLUSH) ? r_flush_cnt + 1'b1 : '0;
      if (r_state != DRAIN)
        r_row <= '0;
      else if (w_out_fire)
        r_row <= w_last_row ? '0 : r_row + 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_row   = r_row;
  assign done      = r_done;

  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    logic signed [DATA_WIDTH-1:0] r_pipe [r+1];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i <= r; i++) r_pipe[i] <= '0;
      end else begin
        r_pipe[0] <= w_a_feed[r*DATA_WIDTH +: DATA_WIDTH];
        for (int i = 1; i <= r; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end
    assign w_a[r][0] = r_pipe[r];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_b_skew
    logic signed [DATA_WIDTH-1:0] r_pipe [c+1];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i <= c; i++) r_pipe[i] <= '0;
      end else begin
        r_pipe[0] <= w_b_feed[c*DATA_WIDTH +: DATA_WIDTH];
        for (int i = 1; i <= c; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end
    assign w_b[0][c] = r_pipe[c];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      gemm_mac_pe #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACCUM_WIDTH(ACCUM_WIDTH)
      ) u_pe (
        .clk  (clk),
        .rst  (rst),
        .clear(r_clear),
        .a_in (w_a[r][c]),
        .b_in (w_b[r][c]),
        .a_out(w_a[r][c+1]),
        .b_out(w_b[r+1][c]),
        .acc  (w_acc[r][c])
      );
    end
  end

  always_comb begin
    out_data = '0;
    for (int c = 0; c < COLS; c++)
      out_data[c*ACCUM_WIDTH +: ACCUM_WIDTH] = w_acc[r_row][c];
  end

endmodule
`default_nettype wire
